// File: rtl/mode_sequencer.sv
// ---------------------------------------------------------------------------
// mode_sequencer
//
// Purpose:
//   Steps a small mode index (player / electone / write modes) on next/prev
//   requests. Requests are held off while a downstream operation is busy or
//   while a post-change guard interval is running; the latest held-off
//   request is remembered in a one-deep pending slot. The current mode
//   decides how the data bus and the button pulses are routed, which mode
//   flags are raised and what goes on the display word. Every output is a
//   flop.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mode_next, mode_prev      one-cycle mode step requests
//   busy                      downstream activity; defers mode changes
//   sw_in, play_in [W]        candidate data sources for in_bus
//   inc, dec                  debounced button pulses to be routed
//   band, sel, len [3]        status fields shown on disp_data
//   mode [MW]                 current mode index
//   mode_onehot [NUM_MODES]   one-hot copy of mode
//   mode_chg                  pulse in the first cycle of a new mode
//   in_bus [W]                routed data bus
//   next, pre, add, redu      routed button pulses
//   electone, music_box,
//   writing, adj              mode flags
//   disp_data [32]            display word
// ---------------------------------------------------------------------------
module mode_sequencer #(
    parameter int NUM_MODES = 4,
    parameter int W         = 16,
    parameter int SETTLE    = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      mode_next,
    input  logic                                      mode_prev,
    input  logic                                      busy,
    input  logic [W-1:0]                              sw_in,
    input  logic [W-1:0]                              play_in,
    input  logic                                      inc,
    input  logic                                      dec,
    input  logic [2:0]                                band,
    input  logic [2:0]                                sel,
    input  logic [2:0]                                len,
    output logic [((NUM_MODES > 2) ? $clog2(NUM_MODES) : 1)-1:0] mode,
    output logic [NUM_MODES-1:0]                      mode_onehot,
    output logic                                      mode_chg,
    output logic [W-1:0]                              in_bus,
    output logic                                      next,
    output logic                                      pre,
    output logic                                      add,
    output logic                                      redu,
    output logic                                      electone,
    output logic                                      music_box,
    output logic                                      writing,
    output logic                                      adj,
    output logic [31:0]                               disp_data
);

    localparam int MW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
    localparam logic [MW-1:0] LAST_MODE = MW'(NUM_MODES - 1);
    localparam logic [3:0]    SETTLE_LD = 4'(SETTLE);

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_NEXT = 2'd1,
        REQ_PREV = 2'd2
    } req_e;

    logic [MW-1:0]        mode_q, mode_d;
    logic [NUM_MODES-1:0] onehot_q, onehot_d;
    logic                 chg_q, chg_d;
    req_e                 pend_q, pend_d;
    logic [3:0]           guard_q, guard_d;
    logic [W-1:0]         in_bus_q, in_bus_d;
    logic                 next_q, next_d;
    logic                 pre_q, pre_d;
    logic                 add_q, add_d;
    logic                 redu_q, redu_d;
    logic                 electone_q, electone_d;
    logic                 music_box_q, music_box_d;
    logic                 writing_q, writing_d;
    logic                 adj_q, adj_d;
    logic [31:0]          disp_q, disp_d;

    req_e req_new;
    req_e req_apply;
    logic blocked;
    logic gated;

    // Request arbitration and mode stepping. A request seen while the block
    // is blocked (busy or guard running) only overwrites the pending slot;
    // once unblocked, a fresh request wins over the pending one and the
    // slot is emptied either way.
    always_comb begin
        req_new   = REQ_NONE;
        req_apply = REQ_NONE;
        pend_d    = pend_q;
        mode_d    = mode_q;
        chg_d     = 1'b0;

        if (mode_next && !mode_prev) begin
            req_new = REQ_NEXT;
        end else if (mode_prev && !mode_next) begin
            req_new = REQ_PREV;
        end

        blocked = busy || (guard_q != 4'd0);

        if (blocked) begin
            if (req_new != REQ_NONE) begin
                pend_d = req_new;
            end
        end else begin
            req_apply = (req_new != REQ_NONE) ? req_new : pend_q;
            pend_d    = REQ_NONE;
        end

        case (req_apply)
            REQ_NEXT: begin
                mode_d = (mode_q == LAST_MODE) ? '0 : mode_q + MW'(1);
                chg_d  = 1'b1;
            end
            REQ_PREV: begin
                mode_d = (mode_q == '0) ? LAST_MODE : mode_q - MW'(1);
                chg_d  = 1'b1;
            end
            default: begin
                mode_d = mode_q;
                chg_d  = 1'b0;
            end
        endcase

        if (chg_d) begin
            guard_d = SETTLE_LD;
        end else if (guard_q != 4'd0) begin
            guard_d = guard_q - 4'd1;
        end else begin
            guard_d = 4'd0;
        end
    end

    // Routing, flags and display are computed from the mode and guard
    // values the registers are about to take, so the registered outputs
    // always agree with the registered mode. The guard counter holds SETTLE
    // in the mode_chg cycle, so in_bus and the pulses stay quiet for SETTLE
    // cycles starting with the mode_chg cycle.
    always_comb begin
        in_bus_d    = '0;
        next_d      = 1'b0;
        pre_d       = 1'b0;
        add_d       = 1'b0;
        redu_d      = 1'b0;
        electone_d  = 1'b0;
        music_box_d = 1'b0;
        writing_d   = 1'b0;
        adj_d       = 1'b0;
        disp_d      = '0;
        onehot_d    = '0;

        for (int i = 0; i < NUM_MODES; i++) begin
            onehot_d[i] = (mode_d == MW'(i));
        end

        if (mode_d == '0) begin
            in_bus_d     = play_in;
            next_d       = inc;
            pre_d        = dec;
            music_box_d  = 1'b1;
            adj_d        = 1'b1;
            disp_d[2:0]   = sel;
            disp_d[18:16] = len;
        end else if (mode_d == MW'(1)) begin
            in_bus_d    = sw_in;
            add_d       = inc;
            redu_d      = dec;
            electone_d  = 1'b1;
            disp_d[2:0] = band;
        end else begin
            in_bus_d    = sw_in;
            writing_d   = 1'b1;
            music_box_d = mode_d[0];
            disp_d[2:0] = 3'(mode_d);
        end

        gated = (guard_d != 4'd0);
        if (gated) begin
            in_bus_d = '0;
            next_d   = 1'b0;
            pre_d    = 1'b0;
            add_d    = 1'b0;
            redu_d   = 1'b0;
        end
    end

    // State and output registers. Reset drops any pending request and any
    // running guard interval and parks the outputs in the mode 0 flag state
    // with everything routed to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= '0;
            onehot_q    <= NUM_MODES'(1);
            chg_q       <= 1'b0;
            pend_q      <= REQ_NONE;
            guard_q     <= 4'd0;
            in_bus_q    <= '0;
            next_q      <= 1'b0;
            pre_q       <= 1'b0;
            add_q       <= 1'b0;
            redu_q      <= 1'b0;
            electone_q  <= 1'b0;
            music_box_q <= 1'b1;
            writing_q   <= 1'b0;
            adj_q       <= 1'b1;
            disp_q      <= '0;
        end else begin
            mode_q      <= mode_d;
            onehot_q    <= onehot_d;
            chg_q       <= chg_d;
            pend_q      <= pend_d;
            guard_q     <= guard_d;
            in_bus_q    <= in_bus_d;
            next_q      <= next_d;
            pre_q       <= pre_d;
            add_q       <= add_d;
            redu_q      <= redu_d;
            electone_q  <= electone_d;
            music_box_q <= music_box_d;
            writing_q   <= writing_d;
            adj_q       <= adj_d;
            disp_q      <= disp_d;
        end
    end

    assign mode        = mode_q;
    assign mode_onehot = onehot_q;
    assign mode_chg    = chg_q;
    assign in_bus      = in_bus_q;
    assign next        = next_q;
    assign pre         = pre_q;
    assign add         = add_q;
    assign redu        = redu_q;
    assign electone    = electone_q;
    assign music_box   = music_box_q;
    assign writing     = writing_q;
    assign adj         = adj_q;
    assign disp_data   = disp_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mode_sequencer
//
// Self-checking bench for mode_sequencer with default parameters
// (4 modes, 16-bit bus, 2 guard cycles). A behavioural model predicts the
// full output vector for every clock edge; predictions are queued when the
// stimulus is applied and popped once the DUT has clocked. Scenario tasks
// add targeted checks with hand-derived constants.
// ---------------------------------------------------------------------------
module tb_mode_sequencer;

    localparam int N      = 4;
    localparam int W      = 16;
    localparam int SETTLE = 2;
    localparam int MW     = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode_next, mode_prev, busy;
    logic [W-1:0]  sw_in, play_in;
    logic          inc, dec;
    logic [2:0]    band, sel, len;
    logic [MW-1:0] mode;
    logic [N-1:0]  mode_onehot;
    logic          mode_chg;
    logic [W-1:0]  in_bus;
    logic          next, pre, add, redu;
    logic          electone, music_box, writing, adj;
    logic [31:0]   disp_data;

    typedef struct packed {
        logic [MW-1:0] mode;
        logic [N-1:0]  onehot;
        logic          chg;
        logic [W-1:0]  in_bus;
        logic          next;
        logic          pre;
        logic          add;
        logic          redu;
        logic          electone;
        logic          music_box;
        logic          writing;
        logic          adj;
        logic [31:0]   disp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;

    int m_mode  = 0;
    int m_pend  = 0;
    int m_guard = 0;

    mode_sequencer #(.NUM_MODES(N), .W(W), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_next  (mode_next),
        .mode_prev  (mode_prev),
        .busy       (busy),
        .sw_in      (sw_in),
        .play_in    (play_in),
        .inc        (inc),
        .dec        (dec),
        .band       (band),
        .sel        (sel),
        .len        (len),
        .mode       (mode),
        .mode_onehot(mode_onehot),
        .mode_chg   (mode_chg),
        .in_bus     (in_bus),
        .next       (next),
        .pre        (pre),
        .add        (add),
        .redu       (redu),
        .electone   (electone),
        .music_box  (music_box),
        .writing    (writing),
        .adj        (adj),
        .disp_data  (disp_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: advances one clock using the inputs currently
    // driven and returns the output vector expected after that edge.
    task automatic model_step(output exp_t e);
        int req;
        int apply;
        logic chg;
        e   = '0;
        chg = 1'b0;
        if (rst) begin
            m_mode      = 0;
            m_pend      = 0;
            m_guard     = 0;
            e.onehot    = 4'b0001;
            e.music_box = 1'b1;
            e.adj       = 1'b1;
        end else begin
            req = 0;
            if (mode_next && !mode_prev) req = 1;
            if (mode_prev && !mode_next) req = 2;
            if (busy || m_guard > 0) begin
                if (req != 0) m_pend = req;
                if (m_guard > 0) m_guard = m_guard - 1;
            end else begin
                apply  = (req != 0) ? req : m_pend;
                m_pend = 0;
                if (apply == 1) begin
                    m_mode = (m_mode + 1) % N;
                    chg    = 1'b1;
                end else if (apply == 2) begin
                    m_mode = (m_mode + N - 1) % N;
                    chg    = 1'b1;
                end
                if (chg) m_guard = SETTLE;
            end
            e.mode           = MW'(m_mode);
            e.onehot[m_mode] = 1'b1;
            e.chg            = chg;
            if (m_mode == 0) begin
                e.in_bus    = play_in;
                e.next      = inc;
                e.pre       = dec;
                e.music_box = 1'b1;
                e.adj       = 1'b1;
                e.disp      = {13'd0, len, 13'd0, sel};
            end else if (m_mode == 1) begin
                e.in_bus   = sw_in;
                e.add      = inc;
                e.redu     = dec;
                e.electone = 1'b1;
                e.disp     = {29'd0, band};
            end else begin
                e.in_bus    = sw_in;
                e.writing   = 1'b1;
                e.music_box = (m_mode % 2) == 1;
                e.disp      = 32'(m_mode);
            end
            if (m_guard > 0) begin
                e.in_bus = '0;
                e.next   = 1'b0;
                e.pre    = 1'b0;
                e.add    = 1'b0;
                e.redu   = 1'b0;
            end
        end
    endtask

    // One clock: queue the prediction, let the DUT clock, then compare
    // the popped prediction with the DUT outputs 1 ns after the edge.
    task automatic step();
        exp_t e;
        exp_t act;
        model_step(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL sb_underflow cycle %0d: queue empty, required one entry", cycle);
        end else begin
            e   = sb.pop_front();
            act = {mode, mode_onehot, mode_chg, in_bus, next, pre, add, redu,
                   electone, music_box, writing, adj, disp_data};
            if (act !== e) begin
                n_fail++;
                $display("[TB] FAIL scoreboard cycle %0d: got %h required %h", cycle, act, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_next = 0; mode_prev = 0; busy = 0;
        sw_in = 16'h5A5A; play_in = 16'h1234; inc = 1; dec = 1;
        band = 3'd3; sel = 3'd5; len = 3'd6;
        step();
        step();
        n_checks++;
        if (mode !== 2'd0) begin
            n_fail++; $display("[TB] FAIL reset_mode: got %0d required 0", mode);
        end
        n_checks++;
        if (mode_onehot !== 4'b0001) begin
            n_fail++; $display("[TB] FAIL reset_onehot: got %b required 0001", mode_onehot);
        end
        n_checks++;
        if ({music_box, adj} !== 2'b11) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %b required 11", {music_box, adj});
        end
        n_checks++;
        if ({mode_chg, in_bus, next, pre, add, redu, electone, writing, disp_data} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_zero: in_bus %h disp %h chg %b", in_bus, disp_data, mode_chg);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (mode_chg !== 1'b0 || mode !== 2'd0) begin
            n_fail++; $display("[TB] FAIL post_reset_chg: got chg %b mode %0d required 0/0", mode_chg, mode);
        end
        n_checks++;
        if (in_bus !== 16'h1234 || next !== 1'b1 || disp_data !== 32'h0006_0005) begin
            n_fail++; $display("[TB] FAIL post_reset_route: in_bus %h disp %h required 1234/00060005", in_bus, disp_data);
        end
        inc = 0; dec = 0;
        step();
    endtask

    task automatic test_next_wrap();
        int chg_cnt = 0;
        for (int p = 0; p < 4; p++) begin
            mode_next = 1'b1;
            step();
            mode_next = 1'b0;
            n_checks++;
            if (mode !== MW'((p + 1) % N) || mode_chg !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL next_wrap_mode: got %0d chg %b required %0d chg 1", mode, mode_chg, (p + 1) % N);
            end
            if (mode_chg === 1'b1) chg_cnt++;
            for (int k = 0; k < 4; k++) begin
                step();
                if (mode_chg === 1'b1) chg_cnt++;
            end
        end
        n_checks++;
        if (chg_cnt != 4) begin
            n_fail++; $display("[TB] FAIL next_wrap_chg_count: got %0d required 4", chg_cnt);
        end
    endtask

    task automatic test_prev_wrap();
        mode_prev = 1'b1;
        step();
        mode_prev = 1'b0;
        n_checks++;
        if (mode !== 2'd3 || mode_onehot !== 4'b1000) begin
            n_fail++; $display("[TB] FAIL prev_wrap_mode: got %0d/%b required 3/1000", mode, mode_onehot);
        end
        n_checks++;
        if (music_box !== 1'b1 || writing !== 1'b1 || disp_data !== 32'd3) begin
            n_fail++; $display("[TB] FAIL prev_wrap_flags: music_box %b writing %b disp %h required 1/1/3", music_box, writing, disp_data);
        end
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic test_simultaneous();
        int chg_cnt = 0;
        mode_next = 1'b1;
        mode_prev = 1'b1;
        step();
        mode_next = 1'b0;
        mode_prev = 1'b0;
        if (mode_chg === 1'b1) chg_cnt++;
        for (int k = 0; k < 5; k++) begin
            step();
            if (mode_chg === 1'b1) chg_cnt++;
        end
        n_checks++;
        if (chg_cnt != 0 || mode !== 2'd3) begin
            n_fail++; $display("[TB] FAIL simultaneous: chg count %0d mode %0d required 0/3", chg_cnt, mode);
        end
    endtask

    task automatic test_busy_pending();
        int chg_cnt = 0;
        busy = 1'b1;
        mode_next = 1'b1;
        step();
        mode_next = 1'b0;
        if (mode_chg === 1'b1) chg_cnt++;
        step(); step();
        mode_prev = 1'b1;
        step();
        mode_prev = 1'b0;
        if (mode_chg === 1'b1) chg_cnt++;
        for (int k = 0; k < 10; k++) begin
            step();
            if (mode_chg === 1'b1) chg_cnt++;
        end
        n_checks++;
        if (chg_cnt != 0 || mode !== 2'd3) begin
            n_fail++; $display("[TB] FAIL busy_hold: chg count %0d mode %0d required 0/3", chg_cnt, mode);
        end
        busy = 1'b0;
        step();
        n_checks++;
        if (mode_chg !== 1'b1 || mode !== 2'd2) begin
            n_fail++; $display("[TB] FAIL busy_release: chg %b mode %0d required 1/2", mode_chg, mode);
        end
        chg_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (mode_chg === 1'b1) chg_cnt++;
        end
        n_checks++;
        if (chg_cnt != 0) begin
            n_fail++; $display("[TB] FAIL busy_single_change: extra chg %0d required 0", chg_cnt);
        end
    endtask

    task automatic test_guard_routing();
        sw_in = 16'hA5A5;
        inc   = 1'b1;
        mode_prev = 1'b1;
        step();
        mode_prev = 1'b0;
        n_checks++;
        if (mode !== 2'd1 || mode_chg !== 1'b1 || add !== 1'b0 || in_bus !== 16'h0000) begin
            n_fail++; $display("[TB] FAIL guard_off0: mode %0d chg %b add %b in_bus %h required 1/1/0/0000", mode, mode_chg, add, in_bus);
        end
        step();
        n_checks++;
        if (add !== 1'b0 || in_bus !== 16'h0000) begin
            n_fail++; $display("[TB] FAIL guard_off1: add %b in_bus %h required 0/0000", add, in_bus);
        end
        step();
        n_checks++;
        if (add !== 1'b1 || in_bus !== 16'hA5A5 || electone !== 1'b1) begin
            n_fail++; $display("[TB] FAIL guard_off2: add %b in_bus %h electone %b required 1/A5A5/1", add, in_bus, electone);
        end
        step();
        inc = 1'b0;
        step();
        n_checks++;
        if (add !== 1'b0 || next !== 1'b0) begin
            n_fail++; $display("[TB] FAIL guard_follow: add %b next %b required 0/0", add, next);
        end
    endtask

    task automatic test_reset_mid_guard();
        int chg_cnt = 0;
        mode_next = 1'b1;
        step();
        step();
        mode_next = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (mode !== 2'd0 || mode_onehot !== 4'b0001 || in_bus !== 16'h0000 || mode_chg !== 1'b0 || music_box !== 1'b1) begin
            n_fail++; $display("[TB] FAIL mid_guard_reset: mode %0d onehot %b in_bus %h chg %b required 0/0001/0000/0", mode, mode_onehot, in_bus, mode_chg);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            if (mode_chg === 1'b1) chg_cnt++;
        end
        n_checks++;
        if (chg_cnt != 0 || mode !== 2'd0) begin
            n_fail++; $display("[TB] FAIL mid_guard_discard: chg count %0d mode %0d required 0/0", chg_cnt, mode);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            mode_next = ($urandom_range(0, 4) == 0);
            mode_prev = ($urandom_range(0, 4) == 0);
            busy      = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 96) == 0);
            sw_in     = W'($urandom);
            play_in   = W'($urandom);
            inc       = 1'($urandom);
            dec       = 1'($urandom);
            band      = 3'($urandom);
            sel       = 3'($urandom);
            len       = 3'($urandom);
            step();
        end
        rst = 1'b0; mode_next = 1'b0; mode_prev = 1'b0; busy = 1'b0;
        step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("[TB] FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_next_wrap();
        test_prev_wrap();
        test_simultaneous();
        test_busy_pending();
        test_guard_routing();
        test_reset_mid_guard();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter NUM_MODES, default 4, meaning number of modes; legal range 2..8.
REQ-002 Parameter W, default 16, meaning data bus width.
REQ-003 Parameter SETTLE, default 2, meaning number of guard cycles after a mode change (0..15).
REQ-004 Derived localparam MW = clog2(NUM_MODES), minimum 1.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 mode_next  in  1  single-cycle pulse requesting the next mode.
REQ-008 mode_prev  in  1  single-cycle pulse requesting the previous mode.
REQ-009 busy  in  1  high while a downstream write or playback is in progress; blocks mode change.
REQ-010 sw_in  in  W  switch bus.
REQ-011 play_in  in  W  player note bus.
REQ-012 inc, dec  in  1 each  debounced button pulses.
REQ-013 band, sel, len  in  3 each  status fields for the display.
REQ-014 mode  out  MW  current mode index.
REQ-015 mode_onehot  out  NUM_MODES  one-hot copy of mode.
REQ-016 mode_chg  out  1  one-cycle pulse in the cycle mode takes its new value.
REQ-017 in_bus  out  W  routed data bus.
REQ-018 next, pre, add, redu  out  1 each  routed button pulses.
REQ-019 electone, music_box, writing, adj  out  1 each  mode flags.
REQ-020 disp_data  out  32  display word.

Function
REQ-021 All outputs SHALL be registered, with 1-cycle latency from a registered input to its routed output; there SHALL be no latches.
REQ-022 A sole mode_next SHALL set mode to (mode+1) mod NUM_MODES; a sole mode_prev SHALL set mode to (mode-1) mod NUM_MODES, with NUM_MODES-1 to 0 and 0 to NUM_MODES-1 wrap-around.
REQ-023 Simultaneous mode_next and mode_prev SHALL be ignored, with no change and no pending request.
REQ-024 A request while busy=1 SHALL be stored in a one-deep pending register, keeping the latest request and overwriting an older one.
REQ-025 A pending request SHALL be applied in the first cycle busy=0; a new request in that same cycle SHALL replace the pending one.
REQ-026 With busy=0, mode SHALL update on the edge after the request cycle, and mode_chg SHALL pulse in that same cycle.
REQ-027 After every mode change, a guard counter SHALL load SETTLE and decrement to 0.
REQ-028 While the guard counter is nonzero, next/pre/add/redu SHALL be 0 and in_bus SHALL be 0.
REQ-029 Mode requests during the guard interval SHALL be treated the same as requests under busy (pended).
REQ-030 Mode 0 (player): music_box=1, adj=1, electone=0, writing=0.
REQ-031 Mode 0 (player) routing: in_bus=play_in, next=inc, pre=dec, add=redu=0.
REQ-032 Mode 0 (player) display: disp_data[2:0]=sel, disp_data[18:16]=len, all other bits 0.
REQ-033 Mode 1 (electone): electone=1, adj=0, music_box=0, writing=0.
REQ-034 Mode 1 (electone) routing: in_bus=sw_in, add=inc, redu=dec, next=pre=0.
REQ-035 Mode 1 (electone) display: disp_data[2:0]=band, all other bits 0.
REQ-036 Modes 2 and above (write): writing=1, electone=0, adj=0, music_box = mode[0].
REQ-037 Modes 2 and above routing: in_bus=sw_in, all four pulses 0.
REQ-038 Modes 2 and above display: disp_data[2:0]=mode zero-extended, all other bits 0.
REQ-039 mode_onehot SHALL always equal 1<<mode, with exactly one bit set.

Reset
REQ-040 While rst=1, the block SHALL set mode=0, mode_onehot=1, clear pending, and clear the guard counter.
REQ-041 While rst=1, mode_chg, in_bus, next, pre, add, redu, electone, writing and disp_data SHALL be 0.
REQ-042 While rst=1, music_box=1 and adj=1.
REQ-043 Reset mid-guard or with a request pending SHALL discard both.
REQ-044 The first cycle after reset SHALL present mode 0 routing with no mode_chg pulse.

Verification
REQ-045 Scenario: reset, then 4 mode_next pulses spaced 5 cycles, NUM_MODES=4 -> mode 1,2,3,0 with 4 mode_chg pulses.
REQ-046 Scenario: a mode_prev pulse from mode 0 -> mode 3, mode_onehot=4'b1000, music_box=1, writing=1.
REQ-047 Scenario: mode_next and mode_prev in the same cycle -> mode unchanged and no mode_chg pulse.
REQ-048 Scenario: busy=1, mode_next then mode_prev, busy falls 10 cycles later -> one change to mode_prev's target, 1 cycle after busy falls.
REQ-049 Scenario: mode 1, SETTLE=2, inc held every cycle -> add=0 for 2 cycles after mode_chg, then add follows inc; in_bus = sw_in = 16'hA5A5.
REQ-050 Scenario: rst asserted 1 cycle into a guard interval with a request pending -> mode=0, no later change, outputs at reset values.
